cordic_channel_scheduler: RTL and testbench
===========================================

Name: cordic_channel_scheduler

Overview:
- Shares one iterative CORDIC core between NCH independent angle/seed requesters (angle generator channels) on a single clock.
- Accepts one request at a time under round-robin arbitration and launches the core with a start pulse.
- Waits for core completion, guarded by a watchdog, and returns the sin/cos result tagged with the channel number on a valid/ready output.

Parameters:
- width, 12, datapath width of angle, x, y and results
- CHW, 2, channel index width; NCH = 2**CHW requesters
- TIMEOUT, 64, max BUSY cycles awaiting core_done before abort (>=2)
- TW, 7, watchdog counter width; must satisfy 2**TW > TIMEOUT

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high
- req_valid  in  NCH  per-channel request valid
- req_ready  out  NCH  per-channel accept; one-hot or zero
- req_angle  in  NCH*width  channel k angle at bits [k*width +: width]
- req_x  in  NCH*width  channel k x_start, same packing
- req_y  in  NCH*width  channel k y_start, same packing
- core_start  out  1  one-cycle launch pulse to the CORDIC core
- core_angle, core_x, core_y  out  width each  operands to the core
- core_done  in  1  core completion pulse
- core_cos, core_sin  in  width each  core results, valid with core_done
- out_valid  out  1  result available
- out_ready  in  1  downstream accept
- out_chan  out  CHW  channel that owns the result
- out_cos, out_sin  out  width each  result data
- out_err  out  1  result aborted by watchdog
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; watchdog 0.
  - last_grant = NCH-1, so channel 0 has first priority after reset.
- State IDLE:
  - Grant g = first k with req_valid[k]=1, searching from last_grant+1 upward modulo NCH.
  - req_ready = one-hot(g) combinationally, only in IDLE and only if some req_valid is high.
  - On transfer, capture angle, x and y of channel g into operand registers and capture g into out_chan.
  - On transfer, set last_grant=g and go to LAUNCH.
  - No request: stay in IDLE.
- State LAUNCH:
  - core_start=1 for exactly this one cycle; clear watchdog; go to BUSY.
- Operand stability: core_angle, core_x and core_y are driven from the operand registers. They are stable from LAUNCH until the next grant.
- State BUSY:
  - Watchdog increments each cycle.
  - If core_done=1: register core_cos/core_sin into out_cos/out_sin, set out_err=0 and out_valid=1, then go to RETURN.
  - Else if watchdog == TIMEOUT-1: set out_cos=out_sin=0, out_err=1 and out_valid=1, then go to RETURN.
  - If core_done and the timeout coincide, core_done wins and out_err=0.
- State RETURN:
  - out_valid stays high; out_chan, out_cos, out_sin and out_err are held stable.
  - When out_ready=1: out_valid=0 on the next edge and go to IDLE.
  - A new grant is possible in the cycle after leaving RETURN, not in the same cycle.
- core_done arriving in IDLE, LAUNCH or RETURN is ignored; no state or output change.
- Requesters are not ready-gated: req_valid may rise or fall at any time. Only the IDLE cycle's values matter.
- Reset mid-operation (any state): return to IDLE next edge. Drop the in-flight result (out_valid=0) and issue no further core_start.
- Minimum turnaround with an immediate core_done and out_ready held high is 4 cycles per request: IDLE, LAUNCH, BUSY, RETURN.
- busy = (state != IDLE).

Test Plan:
- Reset, then ch0 valid with angle=0x07F, x=0x4BF, y=0 -> req_ready=0001 in the first IDLE cycle. core_start pulses in the next cycle with core_angle=0x07F, core_x=0x4BF, core_y=0.
- Core model returns done 12 cycles after start with cos=0x3A0, sin=0x1F0 -> out_valid=1, out_chan=0, out_cos=0x3A0, out_sin=0x1F0, out_err=0. Held until out_ready.
- All four req_valid held high for 8 requests -> grant order 0,1,2,3,0,1,2,3, with exactly one core_start per grant.
- Only ch2 and ch3 valid after last_grant=2 -> ch3 is granted before ch2.
- Core never asserts done -> out_valid exactly TIMEOUT cycles after the first BUSY cycle, with out_err=1 and zero data. The next grant proceeds normally.
- out_ready held low for 20 cycles while core_done pulses again and other channels request -> result, out_chan and req_ready=0 are all held.
- Reset asserted in BUSY -> outputs are 0 at the next edge, and a late core_done is ignored.
- Reset released with ch0 requesting -> ch0 is granted.

Source files
------------

// File: rtl/cordic_channel_scheduler_if.sv
// rtl/cordic_channel_scheduler_if.sv - request, core and result signals of the CORDIC channel scheduler
interface cordic_channel_scheduler_if #(
  parameter int width = 12,
  parameter int CHW   = 2
);
  localparam int NCH = 2 ** CHW;

  logic [NCH-1:0]       req_valid;
  logic [NCH-1:0]       req_ready;
  logic [NCH*width-1:0] req_angle;
  logic [NCH*width-1:0] req_x;
  logic [NCH*width-1:0] req_y;

  logic                 core_start;
  logic [width-1:0]     core_angle;
  logic [width-1:0]     core_x;
  logic [width-1:0]     core_y;
  logic                 core_done;
  logic [width-1:0]     core_cos;
  logic [width-1:0]     core_sin;

  logic                 out_valid;
  logic                 out_ready;
  logic [CHW-1:0]       out_chan;
  logic [width-1:0]     out_cos;
  logic [width-1:0]     out_sin;
  logic                 out_err;
  logic                 busy;

  modport slave (
    input  req_valid, req_angle, req_x, req_y,
    input  core_done, core_cos, core_sin,
    input  out_ready,
    output req_ready, core_start, core_angle, core_x, core_y,
    output out_valid, out_chan, out_cos, out_sin, out_err, busy
  );

  modport master (
    output req_valid, req_angle, req_x, req_y,
    output core_done, core_cos, core_sin,
    output out_ready,
    input  req_ready, core_start, core_angle, core_x, core_y,
    input  out_valid, out_chan, out_cos, out_sin, out_err, busy
  );
endinterface

// File: rtl/cordic_channel_scheduler.sv
// rtl/cordic_channel_scheduler.sv - round-robin sharing of one iterative CORDIC core among NCH requesters
module cordic_channel_scheduler #(
  parameter int width   = 12,
  parameter int CHW     = 2,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  cordic_channel_scheduler_if.slave bus
);
  localparam int NCH = 2 ** CHW;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_BUSY, ST_RETURN} state_e;

  state_e           state_q, state_d;
  logic [CHW-1:0]   last_grant_q, last_grant_d;
  logic [TW-1:0]    wdog_q, wdog_d;
  logic [width-1:0] op_angle_q, op_angle_d;
  logic [width-1:0] op_x_q, op_x_d;
  logic [width-1:0] op_y_q, op_y_d;
  logic [CHW-1:0]   out_chan_q, out_chan_d;
  logic [width-1:0] out_cos_q, out_cos_d;
  logic [width-1:0] out_sin_q, out_sin_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;

  logic             grant_found;
  logic [CHW-1:0]   grant_idx;
  logic [CHW-1:0]   cand;

  // Search starts one past the last winner so every channel gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = last_grant_q + CHW'(i);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    op_angle_d   = op_angle_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    out_chan_d   = out_chan_q;
    out_cos_d    = out_cos_q;
    out_sin_d    = out_sin_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          last_grant_d = grant_idx;
          out_chan_d   = grant_idx;
          op_angle_d   = bus.req_angle[grant_idx*width +: width];
          op_x_d       = bus.req_x[grant_idx*width +: width];
          op_y_d       = bus.req_y[grant_idx*width +: width];
          state_d      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wdog_d  = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        wdog_d = wdog_q + 1'b1;
        // A completion in the final watchdog cycle still counts as success.
        if (bus.core_done) begin
          out_cos_d   = bus.core_cos;
          out_sin_d   = bus.core_sin;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_RETURN;
        end else if (wdog_q == WD_LAST) begin
          out_cos_d   = '0;
          out_sin_d   = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_RETURN;
        end
      end
      ST_RETURN: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= '1;
      wdog_q       <= '0;
      op_angle_q   <= '0;
      op_x_q       <= '0;
      op_y_q       <= '0;
      out_chan_q   <= '0;
      out_cos_q    <= '0;
      out_sin_q    <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      op_angle_q   <= op_angle_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      out_chan_q   <= out_chan_d;
      out_cos_q    <= out_cos_d;
      out_sin_q    <= out_sin_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE && grant_found) ? (NCH'(1) << grant_idx) : '0;
  assign bus.core_start = (state_q == ST_LAUNCH);
  assign bus.core_angle = op_angle_q;
  assign bus.core_x     = op_x_q;
  assign bus.core_y     = op_y_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_chan   = out_chan_q;
  assign bus.out_cos    = out_cos_q;
  assign bus.out_sin    = out_sin_q;
  assign bus.out_err    = out_err_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_cordic_channel_scheduler.sv
// tb/tb_cordic_channel_scheduler.sv - self-checking bench for cordic_channel_scheduler
module tb_cordic_channel_scheduler;
  localparam int W = 12, CHW = 2, NCH = 4, TIMEOUT = 64, TW = 7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cordic_channel_scheduler_if #(.width(W), .CHW(CHW)) bus ();

  cordic_channel_scheduler #(.width(W), .CHW(CHW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0, errors = 0, starts = 0;
  logic [W-1:0] ang [NCH];
  logic [W-1:0] xs  [NCH];
  logic [W-1:0] ys  [NCH];

  always @(negedge clock) if (bus.core_start) starts++;

  typedef struct {
    logic [NCH-1:0] valid;
    int             lat;
    int             grant;
  } vec_t;

  typedef struct {
    logic [CHW-1:0] ch;
    logic [W-1:0]   a, x, y;
  } req_t;

  typedef struct {
    logic [CHW-1:0] ch;
    logic [W-1:0]   c, s;
    logic           e;
  } res_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] f_cos(input logic [W-1:0] a, input logic [W-1:0] x);
    return a ^ x;
  endfunction

  function automatic logic [W-1:0] f_sin(input logic [W-1:0] a, input logic [W-1:0] y);
    return a + y;
  endfunction

  function automatic int model_grant(input logic [NCH-1:0] v, input int last);
    for (int s = 1; s <= NCH; s++)
      if (v[(last + s) % NCH]) return (last + s) % NCH;
    return -1;
  endfunction

  task automatic drive_req(input logic [NCH-1:0] v);
    bus.req_valid = v;
    for (int k = 0; k < NCH; k++) begin
      bus.req_angle[k*W +: W] = ang[k];
      bus.req_x[k*W +: W]     = xs[k];
      bus.req_y[k*W +: W]     = ys[k];
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < NCH; k++) begin
      ang[k] = '0; xs[k] = '0; ys[k] = '0;
    end
    drive_req('0);
    bus.core_done = 1'b0;
    bus.core_cos  = '0;
    bus.core_sin  = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic one_txn(input logic [NCH-1:0] mask, input int lat, input int exp_ch);
    int s0;
    drive_req(mask);
    #1;
    chk("grant", bus.req_ready, 64'(1) << exp_ch);
    s0 = starts;
    tick();
    bus.req_valid = '0;
    chk("start", bus.core_start, 1);
    chk("op_angle", bus.core_angle, ang[exp_ch]);
    chk("op_x", bus.core_x, xs[exp_ch]);
    chk("op_y", bus.core_y, ys[exp_ch]);
    tick();
    for (int i = 0; i < lat; i++) tick();
    bus.core_done = 1'b1;
    bus.core_cos  = f_cos(bus.core_angle, bus.core_x);
    bus.core_sin  = f_sin(bus.core_angle, bus.core_y);
    tick();
    bus.core_done = 1'b0;
    chk("res_valid", bus.out_valid, 1);
    chk("res_chan", bus.out_chan, exp_ch);
    chk("res_cos", bus.out_cos, f_cos(ang[exp_ch], xs[exp_ch]));
    chk("res_sin", bus.out_sin, f_sin(ang[exp_ch], ys[exp_ch]));
    chk("res_err", bus.out_err, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("one_start_per_grant", starts - s0, 1);
    chk("res_released", {bus.out_valid, bus.busy}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t   tbl [15];
    req_t   rq [$];
    res_t   eq [$];
    req_t   r;
    res_t   e;
    int     n, s0, pend, cnt, mlast, g, lsel, lat;
    logic [NCH-1:0] rv;

    tbl = '{
      '{4'b1111, 0, 0}, '{4'b1111, 3, 1}, '{4'b1111, 0, 2}, '{4'b1111, 7, 3},
      '{4'b1111, 1, 0}, '{4'b1111, 0, 1}, '{4'b1111, 2, 2}, '{4'b1111, 0, 3},
      '{4'b0100, 0, 2}, '{4'b1100, 1, 3}, '{4'b1100, 0, 2}, '{4'b0001, 0, 0},
      '{4'b1010, 4, 1}, '{4'b1010, 0, 3}, '{4'b1010, 0, 1}
    };

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_outputs", {bus.out_valid, bus.busy, bus.core_start, bus.out_err, bus.req_ready}, 0);
    chk("rst_data", {bus.out_chan, bus.out_cos, bus.out_sin, bus.core_angle, bus.core_x, bus.core_y}, 0);
    reset = 1'b0;

    ang[0] = 12'h07F; xs[0] = 12'h4BF; ys[0] = 12'h000;
    drive_req(4'b0001);
    #1;
    chk("t1_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    chk("t1_start", bus.core_start, 1);
    chk("t1_ops", {bus.core_angle, bus.core_x, bus.core_y}, {12'h07F, 12'h4BF, 12'h000});
    for (int i = 0; i < 11; i++) tick();
    chk("t1_wait", {bus.out_valid, bus.core_start, bus.busy}, 3'b001);
    tick();
    bus.core_done = 1'b1; bus.core_cos = 12'h3A0; bus.core_sin = 12'h1F0;
    tick();
    bus.core_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t1_result", {bus.out_valid, bus.out_chan, bus.out_cos, bus.out_sin, bus.out_err},
          {1'b1, 2'd0, 12'h3A0, 12'h1F0, 1'b0});
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t1_accept", bus.out_valid, 0);

    do_reset();
    s0 = starts;
    foreach (tbl[i]) begin
      for (int k = 0; k < NCH; k++) begin
        ang[k] = W'(k * 12'h155 + i * 7);
        xs[k]  = W'(12'h800 - k * 12'h0A3 + i);
        ys[k]  = W'(k * 12'h031 + i * 12'h101);
      end
      one_txn(tbl[i].valid, tbl[i].lat, tbl[i].grant);
    end
    chk("tbl_start_count", starts - s0, 15);

    bus.out_ready = 1'b1; bus.core_done = 1'b1;
    bus.core_cos = 12'h123; bus.core_sin = 12'h456;
    drive_req(4'b1111);
    #1;
    chk("turn_g0", bus.req_ready, 4'b0100);
    tick(); tick(); tick();
    chk("turn_ret", {bus.out_valid, bus.out_chan, bus.out_cos, bus.out_sin, bus.req_ready},
        {1'b1, 2'd2, 12'h123, 12'h456, 4'b0000});
    tick();
    chk("turn_g1", {bus.busy, bus.req_ready}, {1'b0, 4'b1000});
    tick(); tick(); tick(); tick();
    chk("turn_g2", {bus.busy, bus.out_valid, bus.req_ready}, {1'b0, 1'b0, 4'b0001});
    bus.req_valid = '0; bus.out_ready = 1'b0; bus.core_done = 1'b0;

    drive_req(4'b0010);
    #1;
    chk("to_grant", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    tick();
    n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("to_latency", n, TIMEOUT);
    for (int i = 0; i < 20; i++) begin
      bus.core_done = i[0];
      bus.core_cos  = 12'hABC; bus.core_sin = 12'hDEF;
      drive_req(4'b1111);
      #1;
      chk("to_hold", {bus.out_valid, bus.out_chan, bus.out_err, bus.out_cos, bus.out_sin, bus.req_ready},
          {1'b1, 2'd1, 1'b1, 12'h000, 12'h000, 4'b0000});
      tick();
    end
    bus.core_done = 1'b0; bus.req_valid = '0; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("to_accept", bus.out_valid, 0);
    one_txn(4'b1111, 2, 2);

    drive_req(4'b1000);
    #1;
    chk("rb_grant", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rb_cleared", {bus.out_valid, bus.busy, bus.core_start, bus.out_chan, bus.core_angle}, 0);
    reset = 1'b0;
    bus.core_done = 1'b1; bus.core_cos = 12'h777; bus.core_sin = 12'h555;
    tick();
    bus.core_done = 1'b0;
    chk("rb_late_done", {bus.out_valid, bus.busy, bus.out_cos}, 0);
    one_txn(4'b0011, 0, 0);

    do_reset();
    mlast = NCH - 1; pend = 0; cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      bus.core_done = 1'b0;
      if (bus.core_start) begin
        lsel = $urandom_range(0, 19);
        lat  = (lsel < 16) ? lsel % 6 : (lsel == 16) ? TIMEOUT - 1 :
               (lsel == 17) ? TIMEOUT : (lsel == 18) ? TIMEOUT - 2 : 200;
        pend = 1; cnt = lat;
        if (rq.size() == 0) chk("rnd_start_unexpected", 1, 0);
        else begin
          r = rq.pop_front();
          chk("rnd_ops", {bus.core_angle, bus.core_x, bus.core_y}, {r.a, r.x, r.y});
          e.ch = r.ch;
          e.e  = (lat >= TIMEOUT);
          e.c  = e.e ? '0 : f_cos(r.a, r.x);
          e.s  = e.e ? '0 : f_sin(r.a, r.y);
          eq.push_back(e);
        end
      end else if (pend != 0) begin
        if (cnt == 0) begin
          bus.core_done = 1'b1;
          bus.core_cos  = f_cos(bus.core_angle, bus.core_x);
          bus.core_sin  = f_sin(bus.core_angle, bus.core_y);
          pend = 0;
        end else cnt--;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.core_done = 1'b1;
        bus.core_cos  = W'($urandom);
        bus.core_sin  = W'($urandom);
      end
      for (int k = 0; k < NCH; k++) begin
        ang[k] = W'($urandom); xs[k] = W'($urandom); ys[k] = W'($urandom);
      end
      rv = (c < 3700) ? NCH'($urandom & $urandom) : '0;
      drive_req(rv);
      bus.out_ready = (c >= 3700) || ($urandom_range(0, 2) != 0);
      #1;
      if (!bus.busy) begin
        g = model_grant(rv, mlast);
        chk("rnd_ready", bus.req_ready, (g < 0) ? 64'(0) : (64'(1) << g));
        if (g >= 0) begin
          r.ch = CHW'(g); r.a = ang[g]; r.x = xs[g]; r.y = ys[g];
          rq.push_back(r);
          mlast = g;
        end
      end else chk("rnd_ready_busy", bus.req_ready, 0);
      if (bus.out_valid) begin
        if (eq.size() == 0) chk("rnd_out_unexpected", 1, 0);
        else begin
          chk("rnd_out", {bus.out_chan, bus.out_cos, bus.out_sin, bus.out_err},
              {eq[0].ch, eq[0].c, eq[0].s, eq[0].e});
          if (bus.out_ready) void'(eq.pop_front());
        end
      end
    end
    chk("rnd_drained", {32'(eq.size()), 32'(rq.size())}, 0);
    chk("rnd_idle", {bus.busy, bus.out_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
